// File: rtl/dm_port_arbiter.sv
// Two-port arbiter/sequencer in front of dm_4k (CPU port C, loader port X).
// DM_ARB_RR_EN selects round-robin tie-breaking; fixed C-priority otherwise.
module dm_port_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [1:0]        c_bsel,
  input  logic              c_bmode,
  input  logic [31:0]       c_din,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [1:0]        x_bsel,
  input  logic              x_bmode,
  input  logic [31:0]       x_din,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [31:0]       x_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  output logic              dm_bmode,
  output logic [1:0]        dm_bsel,
  input  logic [31:0]       dm_dout,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic [1:0]          bsel_q, bsel_d;
  logic                bmode_q, bmode_d;
  logic [31:0]         c_rdata_q, c_rdata_d;
  logic [31:0]         x_rdata_q, x_rdata_d;
  logic                any_req;
  logic                pick;
`ifdef DM_ARB_RR_EN
  logic                rr_q, rr_d;
`endif

  always_comb begin
    any_req   = c_req | x_req;
`ifdef DM_ARB_RR_EN
    // rr_q names the port favoured on the next tie
    pick      = (c_req & x_req) ? rr_q : x_req;
    rr_d      = rr_q;
`else
    pick      = ~c_req;
`endif
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    bsel_d    = bsel_q;
    bmode_d   = bmode_q;
    c_rdata_d = c_rdata_q;
    x_rdata_d = x_rdata_q;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (any_req) begin
          state_d = ACCESS;
          win_d   = pick;
          we_d    = pick ? x_we    : c_we;
          addr_d  = pick ? x_addr  : c_addr;
          din_d   = pick ? x_din   : c_din;
          bsel_d  = pick ? x_bsel  : c_bsel;
          bmode_d = pick ? x_bmode : c_bmode;
`ifdef DM_ARB_RR_EN
          rr_d    = ~pick;
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q) begin
          if (win_q) x_rdata_d = dm_dout;
          else       c_rdata_d = dm_dout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      bsel_q    <= '0;
      bmode_q   <= 1'b0;
      c_rdata_q <= '0;
      x_rdata_q <= '0;
`ifdef DM_ARB_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      bsel_q    <= bsel_d;
      bmode_q   <= bmode_d;
      c_rdata_q <= c_rdata_d;
      x_rdata_q <= x_rdata_d;
`ifdef DM_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign c_gnt    = (state_q == ACCESS) & ~win_q;
  assign x_gnt    = (state_q == ACCESS) &  win_q;
  assign c_rvalid = (state_q == RESP)   & ~win_q;
  assign x_rvalid = (state_q == RESP)   &  win_q;
  assign c_rdata  = c_rdata_q;
  assign x_rdata  = x_rdata_q;
  assign dm_addr  = addr_q;
  assign dm_din   = din_q;
  assign dm_bsel  = bsel_q;
  assign dm_bmode = bmode_q;
  // a write caught by reset never reaches the array
  assign dm_we    = (state_q == ACCESS) & we_q & ~rst;
  assign owner    = win_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural dm_4k model.
module tb_dm_port_arbiter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, c_bmode;
  logic [AW-1:0] c_addr;
  logic [1:0]    c_bsel;
  logic [31:0]   c_din;
  logic          c_gnt, c_rvalid;
  logic [31:0]   c_rdata;
  logic          x_req, x_we, x_bmode;
  logic [AW-1:0] x_addr;
  logic [1:0]    x_bsel;
  logic [31:0]   x_din;
  logic          x_gnt, x_rvalid;
  logic [31:0]   x_rdata;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din, dm_dout;
  logic          dm_we, dm_bmode;
  logic [1:0]    dm_bsel;
  logic          owner;

  logic [31:0]   mem [1024];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_bsel(c_bsel),
    .c_bmode(c_bmode), .c_din(c_din), .c_gnt(c_gnt),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_bsel(x_bsel),
    .x_bmode(x_bmode), .x_din(x_din), .x_gnt(x_gnt),
    .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_bmode(dm_bmode), .dm_bsel(dm_bsel), .dm_dout(dm_dout),
    .owner(owner)
  );

  // dm_4k: byte mode stores din[7:0] into lane bsel
  always @(posedge clk) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (dm_we) begin
      if (dm_bmode) mem[dm_addr][8*dm_bsel +: 8] <= dm_din[7:0];
      else          mem[dm_addr] <= dm_din;
    end
  end
  assign dm_dout = mem[dm_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic c_set(input logic we, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic bm,
                       input logic [1:0] bs);
    c_req = 1'b1; c_we = we; c_addr = a; c_din = d;
    c_bmode = bm; c_bsel = bs;
  endtask

  task automatic x_set(input logic we, input logic [AW-1:0] a,
                       input logic [31:0] d);
    x_req = 1'b1; x_we = we; x_addr = a; x_din = d;
    x_bmode = 1'b0; x_bsel = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    c_req = 0; c_we = 0; c_addr = '0; c_bsel = '0; c_bmode = 0; c_din = '0;
    x_req = 0; x_we = 0; x_addr = '0; x_bsel = '0; x_bmode = 0; x_din = '0;
    tick();
    tick();
    chk("rst_c_gnt", {31'b0, c_gnt}, 32'd0);
    chk("rst_x_rvalid", {31'b0, x_rvalid}, 32'd0);
    chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'h0);
    chk("rst_owner", {31'b0, owner}, 32'd0);
    rst = 1'b0;

    // CPU read
    preload(10'h010, 32'hDEADBEEF);
    c_set(1'b0, 10'h010, 32'h0, 1'b0, 2'b00);
    tick();
    chk("rd_c_gnt", {31'b0, c_gnt}, 32'd1);
    chk("rd_dm_addr", {22'b0, dm_addr}, 32'h010);
    chk("rd_dm_we", {31'b0, dm_we}, 32'd0);
    c_req = 1'b0;
    tick();
    chk("rd_c_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("rd_c_gnt_low", {31'b0, c_gnt}, 32'd0);
    tick();
    chk("rd_idle_rvalid", {31'b0, c_rvalid}, 32'd0);
    chk("rd_idle_gnt", {31'b0, c_gnt}, 32'd0);

    // X write then CPU read
    x_set(1'b1, 10'h3FF, 32'h12345678);
    tick();
    chk("xw_x_gnt", {31'b0, x_gnt}, 32'd1);
    chk("xw_dm_we", {31'b0, dm_we}, 32'd1);
    chk("xw_dm_addr", {22'b0, dm_addr}, 32'h3FF);
    chk("xw_owner", {31'b0, owner}, 32'd1);
    x_req = 1'b0;
    tick();
    chk("xw_dm_we_off", {31'b0, dm_we}, 32'd0);
    chk("xw_x_rvalid", {31'b0, x_rvalid}, 32'd1);
    chk("xw_x_rdata", x_rdata, 32'h0);
    chk("xw_dm_addr_hold", {22'b0, dm_addr}, 32'h3FF);
    tick();
    c_set(1'b0, 10'h3FF, 32'h0, 1'b0, 2'b00);
    tick();
    chk("xw_rb_gnt", {31'b0, c_gnt}, 32'd1);
    c_req = 1'b0;
    tick();
    chk("xw_rb_rdata", c_rdata, 32'h12345678);

    // X request arriving during C's grant is served from RESP
    tick();
    c_set(1'b0, 10'h010, 32'h0, 1'b0, 2'b00);
    tick();
    chk("ov_c_gnt", {31'b0, c_gnt}, 32'd1);
    c_req = 1'b0;
    x_set(1'b0, 10'h3FF, 32'h0);
    tick();
    chk("ov_c_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("ov_x_gnt_resp", {31'b0, x_gnt}, 32'd0);
    tick();
    chk("ov_x_gnt", {31'b0, x_gnt}, 32'd1);
    x_req = 1'b0;
    tick();
    chk("ov_x_rdata", x_rdata, 32'h12345678);
    tick();

    // tie: both held for 4 accesses
    do_reset();
    c_set(1'b0, 10'h010, 32'h0, 1'b0, 2'b00);
    x_set(1'b0, 10'h3FF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef DM_ARB_RR_EN
      chk($sformatf("tie_c_gnt%0d", i), {31'b0, c_gnt}, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("tie_x_gnt%0d", i), {31'b0, x_gnt}, (i % 2 == 1) ? 1 : 0);
`else
      chk($sformatf("tie_c_gnt%0d", i), {31'b0, c_gnt}, 32'd1);
      chk($sformatf("tie_x_gnt%0d", i), {31'b0, x_gnt}, 32'd0);
`endif
      tick();
      chk($sformatf("tie_gap%0d", i), {31'b0, c_gnt | x_gnt}, 32'd0);
    end
    c_req = 1'b0;
    x_req = 1'b0;
    tick();

    // reset during an X write
    preload(10'h020, 32'hAAAA0000);
    x_set(1'b1, 10'h020, 32'h55555555);
    tick();
    chk("ra_x_gnt", {31'b0, x_gnt}, 32'd1);
    rst = 1'b1;
    x_req = 1'b0;
    #1;
    chk("ra_dm_we", {31'b0, dm_we}, 32'd0);
    tick();
    rst = 1'b0;
    chk("ra_x_rvalid", {31'b0, x_rvalid}, 32'd0);
    chk("ra_mem", mem[10'h020], 32'hAAAA0000);
    chk("ra_dm_addr", {22'b0, dm_addr}, 32'h0);
    chk("ra_dm_din", dm_din, 32'h0);
    chk("ra_owner", {31'b0, owner}, 32'd0);
    chk("ra_x_rdata", x_rdata, 32'h0);
    chk("ra_x_gnt", {31'b0, x_gnt}, 32'd0);

    // byte write into lane 2
    preload(10'h004, 32'h0);
    c_set(1'b1, 10'h004, 32'h000000EE, 1'b1, 2'b10);
    tick();
    chk("bw_dm_bmode", {31'b0, dm_bmode}, 32'd1);
    chk("bw_dm_bsel", {30'b0, dm_bsel}, 32'd2);
    c_req = 1'b0;
    tick();
    tick();
    c_set(1'b0, 10'h004, 32'h0, 1'b0, 2'b00);
    tick();
    c_req = 1'b0;
    tick();
    chk("bw_rdata", c_rdata, 32'h00EE0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
